wb_register_slave: RTL and testbench



---
 rtl/wb_register_slave_pkg.sv | 15 +
 rtl/wb_register_slave_resp_pipe.sv | 35 +++
 rtl/wb_register_slave.sv | 85 ++++++++
 tb/tb_wb_register_slave.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_register_slave_pkg.sv
// Shared widths, bank geometry and response encoding for the Wishbone register slave.
package wb_register_slave_pkg;
    localparam int          WB_DW         = 16;
    localparam int          WB_AW         = 16;
    localparam logic [15:0] BASE_ADDR_DEF = 16'h4020;
    localparam int          STATUS_IDX    = 15;
    localparam int          BANK_DEPTH    = 16;

    // One bus termination: valid marks a slot, err selects ERR_O over ACK_O.
    typedef struct packed {
        logic             valid;
        logic             err;
        logic [WB_DW-1:0] data;
    } resp_t;
endpackage

// File: rtl/wb_register_slave_resp_pipe.sv
// Fixed-latency response delay line; the last stage drives the bus termination.
module wb_resp_pipe
    import wb_register_slave_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             CYC_I,
    input  resp_t            resp_i,
    output logic             ACK_O,
    output logic             ERR_O,
    output logic [WB_DW-1:0] DAT_O
);
    resp_t pipe_q [LATENCY];
    resp_t out_w;

    // Shift responses toward the bus; a dropped cycle abandons everything in flight.
    always_ff @(posedge CLK_I) begin
        if (RST_I || !CYC_I) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= resp_i;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // Decode the last stage; data is forced to zero unless this is a normal ACK.
    always_comb begin
        out_w = pipe_q[LATENCY-1];
        ACK_O = out_w.valid & ~out_w.err;
        ERR_O = out_w.valid & out_w.err;
        DAT_O = ACK_O ? out_w.data : '0;
    end
endmodule

// File: rtl/wb_register_slave.sv
// Wishbone B4 pipelined register slave: 15 R/W entries plus a read-only write counter.
module wb_register_slave
    import wb_register_slave_pkg::*;
#(
    parameter int                                WISHBONE_DATAWIDTH    = WB_DW,
    parameter int                                WISHBONE_ADDRESSWIDTH = WB_AW,
    parameter logic [WISHBONE_ADDRESSWIDTH-1:0]  BASE_ADDR             = BASE_ADDR_DEF,
    parameter int                                LATENCY               = 1
) (
    input  logic                                          CLK_I,
    input  logic                                          RST_I,
    input  logic                                          CYC_I,
    input  logic                                          STB_I,
    input  logic                                          WE_I,
    input  logic [WISHBONE_ADDRESSWIDTH-1:0]              ADR_I,
    input  logic [WISHBONE_DATAWIDTH-1:0]                 DAT_I,
    output logic [WISHBONE_DATAWIDTH-1:0]                 DAT_O,
    output logic                                          ACK_O,
    output logic                                          ERR_O,
    output logic                                          STALL_O,
    input  logic                                          dsp_lock,
    output logic [(BANK_DEPTH-1)*WISHBONE_DATAWIDTH-1:0]  reg_q,
    output logic                                          wr_tick,
    output logic [3:0]                                    wr_index
);
    localparam int DW = WISHBONE_DATAWIDTH;
    localparam int AW = WISHBONE_ADDRESSWIDTH;

    logic [BANK_DEPTH-2:0][DW-1:0] regs_q;
    logic [DW-1:0]                 wcnt_q;
    logic                          wr_tick_q;
    logic [3:0]                    wr_index_q;

    logic       accept, hit, bad, wr_en;
    logic [3:0] idx;
    resp_t      resp_d;

    assign STALL_O  = dsp_lock;
    assign reg_q    = regs_q;
    assign wr_tick  = wr_tick_q;
    assign wr_index = wr_index_q;

    // Decode the request and build its response from the pre-edge bank contents.
    always_comb begin
        accept      = CYC_I & STB_I & ~dsp_lock;
        hit         = (ADR_I[AW-1:4] == BASE_ADDR[AW-1:4]);
        idx         = ADR_I[3:0];
        bad         = ~hit | (WE_I & (idx == 4'(STATUS_IDX)));
        wr_en       = accept & WE_I & ~bad;
        resp_d      = '0;
        resp_d.valid = accept;
        resp_d.err   = accept & bad;
        if (accept && !WE_I && hit) begin
            if (idx == 4'(STATUS_IDX)) resp_d.data = wcnt_q;
            else                       resp_d.data = regs_q[idx];
        end
    end

    // Commit writes at the accept edge and flag them one cycle later.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            regs_q     <= '0;
            wcnt_q     <= '0;
            wr_tick_q  <= 1'b0;
            wr_index_q <= '0;
        end else begin
            wr_tick_q <= wr_en;
            if (wr_en) begin
                regs_q[idx] <= DAT_I;
                wcnt_q      <= wcnt_q + {{(DW-1){1'b0}}, 1'b1};
                wr_index_q  <= idx;
            end
        end
    end

    wb_resp_pipe #(.LATENCY(LATENCY)) u_resp_pipe (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .CYC_I  (CYC_I),
        .resp_i (resp_d),
        .ACK_O  (ACK_O),
        .ERR_O  (ERR_O),
        .DAT_O  (DAT_O)
    );
endmodule

// File: tb/tb_wb_register_slave.sv
// Self-checking bench: two slaves (latency 1 and 3) share one bus and are scored against a bus-level model.
module tb_wb_register_slave;
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [15:0] data;
    } m_resp_t;

    logic         clk, rst, cyc, stb, we, lock;
    logic [15:0]  adr, dat;
    logic [15:0]  dat1, dat3;
    logic         ack1, err1, stall1, tick1, ack3, err3, stall3, tick3;
    logic [239:0] regq1, regq3;
    logic [3:0]   widx1, widx3;

    // Reference model state
    logic [15:0] mbank [15];
    logic [15:0] mcnt;
    m_resp_t     s1 [8];
    m_resp_t     s3 [8];
    m_resp_t     e1, e3;
    logic        etk;
    logic [3:0]  ewi;
    int          edge_n;
    int          n_cmp, n_fail;

    wb_register_slave #(.LATENCY(1)) dut1 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(dat),
        .DAT_O(dat1), .ACK_O(ack1), .ERR_O(err1), .STALL_O(stall1), .dsp_lock(lock),
        .reg_q(regq1), .wr_tick(tick1), .wr_index(widx1)
    );

    wb_register_slave #(.LATENCY(3)) dut3 (
        .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(dat),
        .DAT_O(dat3), .ACK_O(ack3), .ERR_O(err3), .STALL_O(stall3), .dsp_lock(lock),
        .reg_q(regq3), .wr_tick(tick3), .wr_index(widx3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [47:0] exp_vec();
        return {e1.valid & ~e1.err, e1.valid & e1.err, e1.data,
                e3.valid & ~e3.err, e3.valid & e3.err, e3.data,
                etk, ewi, lock, etk, ewi, lock};
    endfunction

    function automatic logic [47:0] obs_vec();
        return {ack1, err1, dat1, ack3, err3, dat3, tick1, widx1, stall1, tick3, widx3, stall3};
    endfunction

    function automatic logic [239:0] mreg();
        logic [239:0] r;
        for (int i = 0; i < 15; i++) r[16*i +: 16] = mbank[i];
        return r;
    endfunction

    // Drive one bus cycle, advance one edge, and update the model from the bus rules.
    task automatic step(input logic c, s, w, input logic [15:0] a, d, input logic l, r);
        m_resp_t rs;
        logic    acc, hit, bad;
        int      idx;
        cyc = c; stb = s; we = w; adr = a; dat = d; lock = l; rst = r;
        @(posedge clk);
        edge_n++;
        acc = c & s & ~l;
        hit = (a[15:4] == 12'h402);
        idx = int'(a[3:0]);
        bad = !hit || (w && idx == 15);
        rs  = '0;
        if (acc) begin
            rs.valid = 1'b1;
            rs.err   = bad;
            if (!bad && !w) rs.data = (idx == 15) ? mcnt : mbank[idx];
        end
        etk = 1'b0;
        if (r) begin
            for (int i = 0; i < 15; i++) mbank[i] = '0;
            mcnt = '0;
            ewi  = '0;
            for (int i = 0; i < 8; i++) begin s1[i] = '0; s3[i] = '0; end
        end else begin
            if (!c) begin
                for (int i = 0; i < 8; i++) begin s1[i] = '0; s3[i] = '0; end
            end else if (acc) begin
                s1[edge_n % 8]       = rs;
                s3[(edge_n + 2) % 8] = rs;
            end
            if (acc && w && !bad) begin
                mbank[idx] = d;
                mcnt       = mcnt + 16'd1;
                etk        = 1'b1;
                ewi        = 4'(idx);
            end
        end
        e1 = s1[edge_n % 8]; s1[edge_n % 8] = '0;
        e3 = s3[edge_n % 8]; s3[edge_n % 8] = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            n_cmp++;
            if (obs_vec() !== exp_vec() || regq1 !== mreg() || regq3 !== mreg()) begin
                n_fail++;
                $display("FAIL reset_model e%0d obs=%h exp=%h", edge_n, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if ({ack1, err1, dat1, tick1, widx1, regq1, ack3, err3, dat3} !== '0) begin
            n_fail++;
            $display("FAIL reset_values ack=%b err=%b dat=%h tick=%b widx=%h reg=%h want all zero",
                     ack1, err1, dat1, tick1, widx1, regq1);
        end
    endtask

    task automatic test_basic();
        logic [15:0] a [3] = '{16'h4020, 16'h4025, 16'h0000};
        logic [15:0] d [3] = '{16'h1234, 16'hBEEF, 16'h0000};
        for (int k = 0; k < 3; k++) begin
            step(k < 2, k < 2, 1'b1, a[k], d[k], 1'b0, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec() || regq1 !== mreg() || regq3 !== mreg()) begin
                n_fail++;
                $display("FAIL basic_model e%0d obs=%h exp=%h", edge_n, obs_vec(), exp_vec());
            end
            if (k < 2) begin
                n_cmp++;
                if (ack1 !== 1'b1 || tick1 !== 1'b1 || widx1 !== (k == 0 ? 4'd0 : 4'd5)) begin
                    n_fail++;
                    $display("FAIL basic_ack k=%0d ack=%b tick=%b widx=%0d want 1/1/%0d",
                             k, ack1, tick1, widx1, k == 0 ? 0 : 5);
                end
            end
        end
        n_cmp++;
        if (regq1[15:0] !== 16'h1234 || regq1[95:80] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL basic_regs e0=%h e5=%h want 1234/beef", regq1[15:0], regq1[95:80]);
        end
    endtask

    task automatic test_burst();
        logic [15:0] d [4];
        logic [15:0] got [5];
        int          acks = 0;
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
        for (int k = 0; k < 12; k++) begin
            if (k < 4)       step(1'b1, 1'b1, 1'b1, 16'h4020 + 16'(k), d[k], 1'b0, 1'b0);
            else if (k < 8)  step(1'b1, 1'b1, 1'b0, 16'h4020 + 16'(k - 4), 16'h0, 1'b0, 1'b0);
            else if (k == 8) step(1'b1, 1'b1, 1'b0, 16'h402F, 16'h0, 1'b0, 1'b0);
            else             step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            if (ack1) acks++;
            if (k >= 4 && k <= 8) got[k-4] = dat1;
            n_cmp++;
            if (obs_vec() !== exp_vec() || regq1 !== mreg() || regq3 !== mreg()) begin
                n_fail++;
                $display("FAIL burst_model e%0d obs=%h exp=%h", edge_n, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (acks != 9) begin
            n_fail++;
            $display("FAIL burst_ack_count got %0d want 9", acks);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got[i] !== d[i]) begin
                n_fail++;
                $display("FAIL burst_readback i=%0d got %h want %h", i, got[i], d[i]);
            end
        end
        n_cmp++;
        if (got[4] !== 16'h0004) begin
            n_fail++;
            $display("FAIL burst_counter got %h want 0004", got[4]);
        end
    endtask

    task automatic test_err();
        logic [15:0] cnt_before = mcnt;
        int          errs = 0, acks = 0;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: step(1'b1, 1'b1, 1'b0, 16'h4030, 16'h0, 1'b0, 1'b0);
                1: step(1'b1, 1'b1, 1'b1, 16'h402F, 16'hFFFF, 1'b0, 1'b0);
                2: step(1'b1, 1'b1, 1'b0, 16'h402F, 16'h0, 1'b0, 1'b0);
                default: step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            endcase
            if (k < 2) begin
                errs += int'(err1);
                acks += int'(ack1);
                n_cmp++;
                if (err1 !== 1'b1 || ack1 !== 1'b0 || dat1 !== 16'h0 || tick1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL err_pulse k=%0d err=%b ack=%b dat=%h tick=%b want 1/0/0000/0",
                             k, err1, ack1, dat1, tick1);
                end
            end
            if (k == 2) begin
                n_cmp++;
                if (ack1 !== 1'b1 || dat1 !== cnt_before) begin
                    n_fail++;
                    $display("FAIL err_counter_kept ack=%b dat=%h want 1/%h", ack1, dat1, cnt_before);
                end
            end
            n_cmp++;
            if (obs_vec() !== exp_vec() || regq1 !== mreg() || regq3 !== mreg()) begin
                n_fail++;
                $display("FAIL err_model e%0d obs=%h exp=%h", edge_n, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_lock();
        logic [15:0] a_dat = 16'($urandom);
        logic [15:0] old7  = mbank[7];
        logic [15:0] b_dat = ~old7;
        int          acks = 0, stalls = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 0)     step(1'b1, 1'b1, 1'b1, 16'h4026, a_dat, 1'b0, 1'b0);
            else if (k < 4) step(1'b1, 1'b1, 1'b1, 16'h4027, b_dat, 1'b1, 1'b0);
            else if (k == 4) step(1'b1, 1'b1, 1'b1, 16'h4027, b_dat, 1'b0, 1'b0);
            else            step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            acks   += int'(ack1);
            stalls += int'(stall1);
            if (k >= 1 && k <= 3) begin
                n_cmp++;
                if (regq1[16*7 +: 16] !== old7) begin
                    n_fail++;
                    $display("FAIL lock_no_commit k=%0d e7=%h want %h", k, regq1[16*7 +: 16], old7);
                end
            end
            n_cmp++;
            if (obs_vec() !== exp_vec() || regq1 !== mreg() || regq3 !== mreg()) begin
                n_fail++;
                $display("FAIL lock_model e%0d obs=%h exp=%h", edge_n, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (acks != 2 || stalls != 3 || regq1[16*7 +: 16] !== b_dat || regq1[16*6 +: 16] !== a_dat) begin
            n_fail++;
            $display("FAIL lock_summary acks=%0d stalls=%0d e6=%h e7=%h want 2/3/%h/%h",
                     acks, stalls, regq1[16*6 +: 16], regq1[16*7 +: 16], a_dat, b_dat);
        end
    endtask

    task automatic test_flush();
        int acks3 = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      step(1'b1, 1'b1, 1'b0, 16'h4021, 16'h0, 1'b0, 1'b0);
            else if (k == 1) step(1'b0, 1'b1, 1'b0, 16'h4021, 16'h0, 1'b0, 1'b0);
            else if (k == 6) step(1'b1, 1'b1, 1'b0, 16'h4022, 16'h0, 1'b0, 1'b0);
            else             step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            if (k == 5) begin
                n_cmp++;
                if (acks3 != 0) begin
                    n_fail++;
                    $display("FAIL flush_no_ack got %0d acks want 0", acks3);
                end
            end
            acks3 += int'(ack3);
            if (k == 8) begin
                n_cmp++;
                if (ack3 !== 1'b1 || dat3 !== mbank[2]) begin
                    n_fail++;
                    $display("FAIL flush_recover ack3=%b dat3=%h want 1/%h", ack3, dat3, mbank[2]);
                end
            end
            n_cmp++;
            if (obs_vec() !== exp_vec() || regq1 !== mreg() || regq3 !== mreg()) begin
                n_fail++;
                $display("FAIL flush_model e%0d obs=%h exp=%h", edge_n, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 5))
                0:       a = 16'h4030 + 16'($urandom_range(0, 3));
                1:       a = 16'h401F;
                2:       a = 16'($urandom);
                default: a = 16'h4020 + 16'($urandom_range(0, 15));
            endcase
            step($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, 1'($urandom),
                 a, 16'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
            n_cmp++;
            if (obs_vec() !== exp_vec() || regq1 !== mreg() || regq3 !== mreg()) begin
                n_fail++;
                $display("FAIL random_model e%0d obs=%h exp=%h", edge_n, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_wrap();
        while (mcnt != 16'hFFFF)
            step(1'b1, 1'b1, 1'b1, 16'h4020 + 16'($urandom_range(0, 14)), 16'($urandom), 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h402F, 16'h0, 1'b0, 1'b0);
        n_cmp++;
        if (ack1 !== 1'b1 || dat1 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_full ack=%b dat=%h want 1/ffff", ack1, dat1);
        end
        step(1'b1, 1'b1, 1'b1, 16'h4020, 16'h5A5A, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h402F, 16'h0, 1'b0, 1'b0);
        n_cmp++;
        if (ack1 !== 1'b1 || dat1 !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_zero ack=%b dat=%h want 1/0000", ack1, dat1);
        end
        n_cmp++;
        if (obs_vec() !== exp_vec() || regq1 !== mreg() || regq3 !== mreg()) begin
            n_fail++;
            $display("FAIL wrap_model e%0d obs=%h exp=%h", edge_n, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        for (int k = 0; k < 7; k++) begin
            if (k < 2)       step(1'b1, 1'b1, 1'b0, 16'h4020 + 16'(k), 16'h0, 1'b0, 1'b0);
            else if (k == 2) step(1'b1, 1'b1, 1'b0, 16'h4022, 16'h0, 1'b0, 1'b1);
            else             step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            if (k >= 2) stale += int'(ack1) + int'(ack3) + int'(err1) + int'(err3);
            n_cmp++;
            if (obs_vec() !== exp_vec() || regq1 !== mreg() || regq3 !== mreg()) begin
                n_fail++;
                $display("FAIL rstmid_model e%0d obs=%h exp=%h", edge_n, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (stale != 0 || regq1 !== '0 || regq3 !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear stale=%0d reg1=%h want 0 and all-zero bank", stale, regq1);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; edge_n = 0;
        cyc = 0; stb = 0; we = 0; adr = '0; dat = '0; lock = 0; rst = 1;
        mcnt = '0; etk = 0; ewi = '0; e1 = '0; e3 = '0;
        for (int i = 0; i < 15; i++) mbank[i] = '0;
        for (int i = 0; i < 8; i++) begin s1[i] = '0; s3[i] = '0; end
        @(negedge clk);
        test_reset();
        test_basic();
        test_burst();
        test_err();
        test_lock();
        test_flush();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
